rob_queue: RTL and testbench

- In-order reorder buffer that receives decoded instructions from the IDROB pipeline register and sits on the far end of the ID→ROB interface.
- Allocates a ROB entry per dispatched instruction and returns its tag, which becomes the rename reference for the regfile.
- Collects out-of-order writebacks and serves tag lookups for operands marked as references.
- Retires entries in program order toward the regfile writer and exception unit.

---
 rtl/rob_queue.sv | 165 ++++++++++++++++
 tb/tb_rob_queue.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_queue.sv
// rtl/rob_queue.sv - in-order reorder buffer: dispatch allocation, out-of-order writeback,
// tag lookup with writeback bypass, and registered in-order retirement.
module rob_queue #(
   parameter int DEPTH_LOG2 = 4,
   parameter int EXC_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  commit_stall,
   input  logic                  disp_en,
   input  logic                  disp_reg_write_en,
   input  logic [4:0]            disp_reg_write_addr,
   input  logic [EXC_WIDTH-1:0]  disp_exception_type,
   input  logic [31:0]           disp_pc,
   output logic                  disp_ready,
   output logic [DEPTH_LOG2-1:0] disp_id,
   input  logic                  wb_en,
   input  logic [DEPTH_LOG2-1:0] wb_id,
   input  logic [31:0]           wb_data,
   input  logic [EXC_WIDTH-1:0]  wb_exception_type,
   input  logic [DEPTH_LOG2-1:0] rd_id_1,
   input  logic [DEPTH_LOG2-1:0] rd_id_2,
   output logic                  rd_done_1,
   output logic                  rd_done_2,
   output logic [31:0]           rd_data_1,
   output logic [31:0]           rd_data_2,
   output logic                  commit_en,
   output logic [DEPTH_LOG2-1:0] commit_id,
   output logic                  commit_reg_write_en,
   output logic [4:0]            commit_reg_write_addr,
   output logic [31:0]           commit_data,
   output logic [EXC_WIDTH-1:0]  commit_exception_type,
   output logic [31:0]           commit_pc,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [DEPTH_LOG2:0]   head;
   logic [DEPTH_LOG2:0]   tail;
   logic [DEPTH_LOG2-1:0] head_idx;
   logic [DEPTH_LOG2-1:0] tail_idx;
   logic                  full;
   logic                  disp_accept;
   logic                  wb_hit;
   logic                  commit_fire;

   logic [DEPTH-1:0]      valid;
   logic [DEPTH-1:0]      done;
   logic [DEPTH-1:0]      e_we;
   logic [4:0]            e_addr [DEPTH];
   logic [31:0]           e_pc   [DEPTH];
   logic [31:0]           e_data [DEPTH];
   logic [EXC_WIDTH-1:0]  e_exc  [DEPTH];

   assign head_idx = head[DEPTH_LOG2-1:0];
   assign tail_idx = tail[DEPTH_LOG2-1:0];

   // Equal indices with differing wrap bits means every slot is occupied.
   assign full  = (head_idx == tail_idx) && (head[DEPTH_LOG2] != tail[DEPTH_LOG2]);
   assign empty = (head == tail);
   assign count = tail - head;

   assign disp_ready  = !full;
   assign disp_id     = tail_idx;
   assign disp_accept = disp_en && !full;
   assign wb_hit      = wb_en && valid[wb_id];
   assign commit_fire = !empty && valid[head_idx] && done[head_idx] && !commit_stall;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         valid <= '0;
         done  <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         valid <= '0;
         done  <= '0;
      end else begin
         if (commit_fire) begin
            head            <= head + 1'b1;
            valid[head_idx] <= 1'b0;
         end
         if (wb_hit) begin
            done[wb_id] <= 1'b1;
         end
         // The tail slot is never valid, so these never collide with the writes above.
         if (disp_accept) begin
            tail            <= tail + 1'b1;
            valid[tail_idx] <= 1'b1;
            done[tail_idx]  <= (disp_exception_type != '0);
         end
      end
   end

   // Payload carries no reset; valid/done gate every use of it.
   always_ff @(posedge clk) begin
      if (!flush) begin
         if (wb_hit) begin
            e_data[wb_id] <= wb_data;
            if (wb_exception_type != '0) begin
               e_exc[wb_id] <= wb_exception_type;
            end
         end
         if (disp_accept) begin
            e_we[tail_idx]   <= disp_reg_write_en;
            e_addr[tail_idx] <= disp_reg_write_addr;
            e_pc[tail_idx]   <= disp_pc;
            e_exc[tail_idx]  <= disp_exception_type;
            e_data[tail_idx] <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         commit_en             <= 1'b0;
         commit_id             <= '0;
         commit_reg_write_en   <= 1'b0;
         commit_reg_write_addr <= '0;
         commit_data           <= '0;
         commit_exception_type <= '0;
         commit_pc             <= '0;
      end else if (flush) begin
         commit_en             <= 1'b0;
         commit_id             <= '0;
         commit_reg_write_en   <= 1'b0;
         commit_reg_write_addr <= '0;
         commit_data           <= '0;
         commit_exception_type <= '0;
         commit_pc             <= '0;
      end else begin
         commit_en <= commit_fire;
         if (commit_fire) begin
            commit_id             <= head_idx;
            commit_reg_write_en   <= e_we[head_idx];
            commit_reg_write_addr <= e_addr[head_idx];
            commit_data           <= e_data[head_idx];
            commit_exception_type <= e_exc[head_idx];
            commit_pc             <= e_pc[head_idx];
         end
      end
   end

   // A writeback in flight this cycle wins over the stored result.
   always_comb begin
      rd_done_1 = valid[rd_id_1] && done[rd_id_1];
      rd_data_1 = rd_done_1 ? e_data[rd_id_1] : 32'd0;
      if (wb_en && (wb_id == rd_id_1)) begin
         rd_done_1 = 1'b1;
         rd_data_1 = wb_data;
      end
      rd_done_2 = valid[rd_id_2] && done[rd_id_2];
      rd_data_2 = rd_done_2 ? e_data[rd_id_2] : 32'd0;
      if (wb_en && (wb_id == rd_id_2)) begin
         rd_done_2 = 1'b1;
         rd_data_2 = wb_data;
      end
   end

endmodule

// File: tb/tb_rob_queue.sv
// tb/tb_rob_queue.sv - scoreboard bench for rob_queue.
module tb_rob_queue;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        commit_stall = 1'b0;
   logic        disp_en = 1'b0;
   logic        disp_reg_write_en = 1'b0;
   logic [4:0]  disp_reg_write_addr = '0;
   logic [7:0]  disp_exception_type = '0;
   logic [31:0] disp_pc = '0;
   logic        disp_ready;
   logic [3:0]  disp_id;
   logic        wb_en = 1'b0;
   logic [3:0]  wb_id = '0;
   logic [31:0] wb_data = '0;
   logic [7:0]  wb_exception_type = '0;
   logic [3:0]  rd_id_1 = '0;
   logic [3:0]  rd_id_2 = '0;
   logic        rd_done_1, rd_done_2;
   logic [31:0] rd_data_1, rd_data_2;
   logic        commit_en;
   logic [3:0]  commit_id;
   logic        commit_reg_write_en;
   logic [4:0]  commit_reg_write_addr;
   logic [31:0] commit_data;
   logic [7:0]  commit_exception_type;
   logic [31:0] commit_pc;
   logic        empty;
   logic [4:0]  count;

   rob_queue #(.DEPTH_LOG2(4), .EXC_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .flush(flush), .commit_stall(commit_stall),
      .disp_en(disp_en), .disp_reg_write_en(disp_reg_write_en),
      .disp_reg_write_addr(disp_reg_write_addr), .disp_exception_type(disp_exception_type),
      .disp_pc(disp_pc), .disp_ready(disp_ready), .disp_id(disp_id),
      .wb_en(wb_en), .wb_id(wb_id), .wb_data(wb_data), .wb_exception_type(wb_exception_type),
      .rd_id_1(rd_id_1), .rd_id_2(rd_id_2), .rd_done_1(rd_done_1), .rd_done_2(rd_done_2),
      .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
      .commit_en(commit_en), .commit_id(commit_id), .commit_reg_write_en(commit_reg_write_en),
      .commit_reg_write_addr(commit_reg_write_addr), .commit_data(commit_data),
      .commit_exception_type(commit_exception_type), .commit_pc(commit_pc),
      .empty(empty), .count(count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass = 0;
   int n_commits = 0;
   int n_disp = 0;

   logic [31:0] m_pc   [16];
   logic [31:0] m_data [16];
   logic [7:0]  m_exc  [16];
   logic [4:0]  m_addr [16];
   logic        m_we   [16];
   bit          m_valid[16];
   bit          m_done [16];
   logic [3:0]  tag_q[$];
   int          m_count = 0;
   logic [4:0]  m_tail = '0;
   logic [3:0]  mon_t;

   // Scoreboard: every retirement must match the oldest outstanding dispatch.
   always @(posedge clk) begin
      #1;
      if (rst && commit_en) begin
         n_checks++;
         n_commits++;
         if (tag_q.size() == 0) begin
            $display("FAIL commit_unexpected got id=%0d pc=%h required no commit", commit_id, commit_pc);
         end else begin
            mon_t = tag_q.pop_front();
            if (commit_id !== mon_t || commit_pc !== m_pc[mon_t] || commit_data !== m_data[mon_t] ||
                commit_exception_type !== m_exc[mon_t] || commit_reg_write_en !== m_we[mon_t] ||
                commit_reg_write_addr !== m_addr[mon_t])
               $display("FAIL commit_fields got id=%0d pc=%h data=%h exc=%h we=%0b addr=%0d required id=%0d pc=%h data=%h exc=%h we=%0b addr=%0d",
                        commit_id, commit_pc, commit_data, commit_exception_type, commit_reg_write_en,
                        commit_reg_write_addr, mon_t, m_pc[mon_t], m_data[mon_t], m_exc[mon_t],
                        m_we[mon_t], m_addr[mon_t]);
            else
               n_pass++;
            m_valid[mon_t] = 1'b0;
            m_count--;
         end
      end
   end

   task automatic model_clear();
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 1'b0;
         m_done[i]  = 1'b0;
      end
      tag_q.delete();
      m_count = 0;
      m_tail  = '0;
   endtask

   task automatic step();
      @(negedge clk);
      disp_en = 1'b0;
      wb_en   = 1'b0;
      flush   = 1'b0;
   endtask

   task automatic drive_disp(input logic [31:0] pc, input logic we, input logic [4:0] addr,
                             input logic [7:0] exc);
      logic [3:0] t;
      disp_en = 1'b1;
      disp_pc = pc;
      disp_reg_write_en = we;
      disp_reg_write_addr = addr;
      disp_exception_type = exc;
      if (m_count < 16) begin
         t = m_tail[3:0];
         m_pc[t] = pc; m_we[t] = we; m_addr[t] = addr; m_exc[t] = exc;
         m_data[t] = 32'd0;
         m_valid[t] = 1'b1;
         m_done[t] = (exc != 8'd0);
         tag_q.push_back(t);
         m_tail = m_tail + 5'd1;
         m_count++;
         n_disp++;
      end
   endtask

   task automatic drive_wb(input logic [3:0] tag, input logic [31:0] data, input logic [7:0] exc);
      wb_en = 1'b1;
      wb_id = tag;
      wb_data = data;
      wb_exception_type = exc;
      if (m_valid[tag]) begin
         m_done[tag] = 1'b1;
         m_data[tag] = data;
         if (exc != 8'd0) m_exc[tag] = exc;
      end
   endtask

   task automatic do_flush();
      @(negedge clk);
      disp_en = 1'b0;
      wb_en = 1'b0;
      flush = 1'b1;
      model_clear();
      step();
   endtask

   task automatic test_reset();
      #2 rst = 1'b0;
      model_clear();
      #1;
      n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty got=%0b required=1", empty); else n_pass++;
      n_checks++; if (count !== 5'd0) $display("FAIL reset_count got=%0d required=0", count); else n_pass++;
      n_checks++; if (disp_ready !== 1'b1) $display("FAIL reset_disp_ready got=%0b required=1", disp_ready); else n_pass++;
      n_checks++; if (disp_id !== 4'd0) $display("FAIL reset_disp_id got=%0d required=0", disp_id); else n_pass++;
      n_checks++; if (commit_en !== 1'b0) $display("FAIL reset_commit_en got=%0b required=0", commit_en); else n_pass++;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      step();
      n_checks++; if (empty !== 1'b1 || commit_en !== 1'b0) $display("FAIL post_reset got empty=%0b commit_en=%0b required 1/0", empty, commit_en); else n_pass++;
   endtask

   task automatic test_in_order();
      int c0;
      drive_disp(32'hbfc00000, 1'b1, 5'd8, 8'd0); step();
      drive_disp(32'hbfc00004, 1'b1, 5'd9, 8'd0); step();
      c0 = n_commits;
      drive_wb(4'd1, 32'h22, 8'd0); step();
      step(); step();
      n_checks++; if (n_commits != c0 || commit_en !== 1'b0) $display("FAIL inorder_hold got commits=%0d commit_en=%0b required commits=%0d commit_en=0", n_commits - c0, commit_en, 0); else n_pass++;
      drive_wb(4'd0, 32'h11, 8'd0); step();
      n_checks++; if (commit_en !== 1'b0) $display("FAIL inorder_latency got commit_en=%0b required=0", commit_en); else n_pass++;
      step();
      n_checks++; if (commit_en !== 1'b1 || commit_data !== 32'h11 || commit_pc !== 32'hbfc00000) $display("FAIL inorder_first got en=%0b data=%h pc=%h required 1/00000011/bfc00000", commit_en, commit_data, commit_pc); else n_pass++;
      step();
      n_checks++; if (commit_en !== 1'b1 || commit_data !== 32'h22 || commit_pc !== 32'hbfc00004) $display("FAIL inorder_second got en=%0b data=%h pc=%h required 1/00000022/bfc00004", commit_en, commit_data, commit_pc); else n_pass++;
      step();
      n_checks++; if (commit_en !== 1'b0 || commit_data !== 32'h22 || empty !== 1'b1) $display("FAIL inorder_idle got en=%0b data=%h empty=%0b required 0/00000022/1", commit_en, commit_data, empty); else n_pass++;
   endtask

   task automatic test_full();
      do_flush();
      for (int i = 0; i < 16; i++) begin
         drive_disp(32'h1000 + 32'(i * 4), 1'b1, i[4:0], 8'd0);
         step();
      end
      n_checks++; if (disp_ready !== 1'b0 || count !== 5'd16 || disp_id !== 4'd0) $display("FAIL full_state got ready=%0b count=%0d id=%0d required 0/16/0", disp_ready, count, disp_id); else n_pass++;
      drive_disp(32'hdeadbeef, 1'b1, 5'd1, 8'd0); step();
      n_checks++; if (count !== 5'd16 || disp_ready !== 1'b0) $display("FAIL full_ignore got count=%0d ready=%0b required 16/0", count, disp_ready); else n_pass++;
      drive_wb(4'd0, 32'h500, 8'd0); step();
      step();
      n_checks++; if (commit_en !== 1'b1 || disp_ready !== 1'b1 || disp_id !== 4'd0 || count !== 5'd15) $display("FAIL full_free got en=%0b ready=%0b id=%0d count=%0d required 1/1/0/15", commit_en, disp_ready, disp_id, count); else n_pass++;
      drive_disp(32'h2000, 1'b1, 5'd3, 8'd0); step();
      n_checks++; if (count !== 5'd16) $display("FAIL full_wrap_count got=%0d required=16", count); else n_pass++;
      for (int i = 1; i < 16; i++) begin
         drive_wb(i[3:0], 32'h600 + 32'(i), 8'd0);
         step();
      end
      drive_wb(4'd0, 32'h777, 8'd0); step();
      repeat (4) step();
      n_checks++; if (empty !== 1'b1 || count !== 5'd0) $display("FAIL full_drain got empty=%0b count=%0d required 1/0", empty, count); else n_pass++;
   endtask

   task automatic test_bypass();
      do_flush();
      for (int i = 0; i < 4; i++) begin
         drive_disp(32'h3000 + 32'(i * 4), 1'b0, 5'd0, 8'd0);
         step();
      end
      rd_id_1 = 4'd3;
      rd_id_2 = 4'd2;
      drive_wb(4'd3, 32'habcdef00, 8'd0);
      #1;
      n_checks++; if (rd_done_1 !== 1'b1 || rd_data_1 !== 32'habcdef00) $display("FAIL bypass_hit got done=%0b data=%h required 1/abcdef00", rd_done_1, rd_data_1); else n_pass++;
      n_checks++; if (rd_done_2 !== 1'b0 || rd_data_2 !== 32'd0) $display("FAIL bypass_pending got done=%0b data=%h required 0/00000000", rd_done_2, rd_data_2); else n_pass++;
      step();
      #1;
      n_checks++; if (rd_done_1 !== 1'b1 || rd_data_1 !== 32'habcdef00) $display("FAIL lookup_stored got done=%0b data=%h required 1/abcdef00", rd_done_1, rd_data_1); else n_pass++;
      drive_wb(4'd7, 32'h12345678, 8'd0); step();
      rd_id_2 = 4'd7;
      #1;
      n_checks++; if (rd_done_2 !== 1'b0 || rd_data_2 !== 32'd0) $display("FAIL wb_invalid got done=%0b data=%h required 0/00000000", rd_done_2, rd_data_2); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         drive_wb(i[3:0], 32'h40 + 32'(i), 8'd0);
         step();
      end
      repeat (5) step();
      n_checks++; if (empty !== 1'b1) $display("FAIL bypass_drain got empty=%0b required=1", empty); else n_pass++;
   endtask

   task automatic test_exception();
      do_flush();
      commit_stall = 1'b1;
      drive_disp(32'h5000, 1'b0, 5'd0, 8'h04); step();
      repeat (3) step();
      n_checks++; if (commit_en !== 1'b0 || count !== 5'd1) $display("FAIL exc_stall got en=%0b count=%0d required 0/1", commit_en, count); else n_pass++;
      commit_stall = 1'b0;
      step();
      n_checks++; if (commit_en !== 1'b1 || commit_exception_type !== 8'h04 || commit_pc !== 32'h5000) $display("FAIL exc_commit got en=%0b exc=%h pc=%h required 1/04/00005000", commit_en, commit_exception_type, commit_pc); else n_pass++;
      drive_disp(32'h5004, 1'b1, 5'd4, 8'd0); step();
      drive_wb(4'd1, 32'h77, 8'h10); step();
      step();
      n_checks++; if (commit_en !== 1'b1 || commit_exception_type !== 8'h10 || commit_data !== 32'h77) $display("FAIL exc_wb got en=%0b exc=%h data=%h required 1/10/00000077", commit_en, commit_exception_type, commit_data); else n_pass++;
   endtask

   task automatic test_flush();
      do_flush();
      for (int i = 0; i < 5; i++) begin
         drive_disp(32'h6000 + 32'(i * 4), 1'b1, 5'd2, 8'd0);
         step();
      end
      drive_wb(4'd0, 32'h99, 8'd0); step();
      flush = 1'b1;
      model_clear();
      step();
      n_checks++; if (empty !== 1'b1 || count !== 5'd0 || commit_en !== 1'b0) $display("FAIL flush_clear got empty=%0b count=%0d en=%0b required 1/0/0", empty, count, commit_en); else n_pass++;
      drive_disp(32'h7000, 1'b1, 5'd1, 8'h02); step();
      drive_disp(32'h7004, 1'b1, 5'd2, 8'd0); step();
      n_checks++; if (commit_en !== 1'b1) $display("FAIL pre_rst_commit got en=%0b required=1", commit_en); else n_pass++;
      #2 rst = 1'b0;
      model_clear();
      #1;
      n_checks++; if (empty !== 1'b1 || count !== 5'd0 || commit_en !== 1'b0 || commit_pc !== 32'd0 || disp_id !== 4'd0) $display("FAIL async_rst got empty=%0b count=%0d en=%0b pc=%h id=%0d required 1/0/0/00000000/0", empty, count, commit_en, commit_pc, disp_id); else n_pass++;
      @(negedge clk);
      rst = 1'b1;
      step();
   endtask

   task automatic test_back_to_back();
      int pend, start, sz, d0;
      logic [3:0] t;
      do_flush();
      d0 = n_commits;
      n_disp = 0;
      for (int cyc = 0; cyc < 240; cyc++) begin
         commit_stall = (cyc < 40) && ($urandom_range(0, 4) == 0);
         sz = tag_q.size();
         pend = -1;
         if (sz > 0 && $urandom_range(0, 2) != 0) begin
            start = $urandom_range(0, sz - 1);
            for (int k = 0; k < sz; k++) begin
               t = tag_q[(start + k) % sz];
               if (pend < 0 && !m_done[t]) pend = int'(t);
            end
         end
         if (pend >= 0)
            drive_wb(pend[3:0], $urandom(), ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 255)) : 8'd0);
         if (cyc < 40 && $urandom_range(0, 3) != 0)
            drive_disp($urandom(), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                       ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'd0);
         step();
         if (cyc > 40 && m_count == 0) break;
      end
      repeat (3) step();
      n_checks++; if (empty !== 1'b1 || count !== 5'd0) $display("FAIL b2b_drain got empty=%0b count=%0d required 1/0", empty, count); else n_pass++;
      n_checks++; if (n_commits - d0 != n_disp) $display("FAIL b2b_commits got=%0d required=%0d", n_commits - d0, n_disp); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_in_order();
      test_full();
      test_bypass();
      test_exception();
      test_flush();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t required completion", $time);
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1);
   end

endmodule
